// File: rtl/return_address_stack.sv
// Return address stack: a LIFO of call return addresses beside the program
// counter. Pushed on a call, popped on a return. The top entry is presented
// combinationally so the counter can load it in the same cycle as the pop.
module return_address_stack #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_enable,
    input  logic [DATA_WIDTH-1:0] push_address,
    input  logic                  pop_enable,
    input  logic                  clear_errors,
    output logic [DATA_WIDTH-1:0] return_address,
    output logic                  empty,
    output logic                  full,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] ONE_CNT   = (PTR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] entry_reg [DEPTH];
    logic [PTR_WIDTH:0]    count_reg;
    logic [PTR_WIDTH:0]    count_next;
    logic [PTR_WIDTH:0]    count_minus_one;
    logic [PTR_WIDTH-1:0]  top_idx;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic                  is_empty;
    logic                  is_full;
    logic                  wr_en;
    logic [PTR_WIDTH-1:0]  wr_idx;
    logic                  overflow_set;
    logic                  underflow_set;
    logic [DEPTH-1:0]      wr_sel;

    assign is_empty        = (count_reg == '0);
    assign is_full         = (count_reg == DEPTH_CNT);
    assign count_minus_one = count_reg - ONE_CNT;
    assign top_idx         = count_minus_one[PTR_WIDTH-1:0];

    // Decode the next count, the entry to write and the error events.
    // A push on a full stack is dropped so the oldest entries survive; a
    // push+pop on a non-empty stack simply replaces the top entry.
    always_comb begin
        count_next    = count_reg;
        wr_en         = 1'b0;
        wr_idx        = '0;
        overflow_set  = 1'b0;
        underflow_set = 1'b0;
        if (push_enable && !pop_enable) begin
            if (is_full) begin
                overflow_set = 1'b1;
            end else begin
                wr_en      = 1'b1;
                wr_idx     = count_reg[PTR_WIDTH-1:0];
                count_next = count_reg + ONE_CNT;
            end
        end else if (!push_enable && pop_enable) begin
            if (is_empty) begin
                underflow_set = 1'b1;
            end else begin
                count_next = count_minus_one;
            end
        end else if (push_enable && pop_enable) begin
            wr_en = 1'b1;
            if (is_empty) begin
                wr_idx        = '0;
                count_next    = ONE_CNT;
                underflow_set = 1'b1;
            end else begin
                wr_idx = top_idx;
            end
        end
    end

    // One write-select line per storage entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_idx == PTR_WIDTH'(gi));
        end
    endgenerate

    // Storage update; reset wipes every entry so stale addresses never leak.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                entry_reg[i] <= '0;
            end else if (wr_sel[i]) begin
                entry_reg[i] <= push_address;
            end
        end
    end

    // Occupancy counter and sticky error flags; a new error beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (overflow_set) begin
                overflow_reg <= 1'b1;
            end else if (clear_errors) begin
                overflow_reg <= 1'b0;
            end
            if (underflow_set) begin
                underflow_reg <= 1'b1;
            end else if (clear_errors) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    assign return_address = is_empty ? '0 : entry_reg[top_idx];
    assign empty          = is_empty;
    assign full           = is_full;
    assign count          = count_reg;
    assign overflow       = overflow_reg;
    assign underflow      = underflow_reg;

endmodule

// File: tb/tb_return_address_stack.sv
// Directed bench for return_address_stack: each step drives one cycle of
// strobes, then the visible state is compared with hand-computed values.
module tb_return_address_stack;

    localparam int DATA_WIDTH = 16;
    localparam int DEPTH      = 8;
    localparam int PTR_WIDTH  = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  push_enable;
    logic [DATA_WIDTH-1:0] push_address;
    logic                  pop_enable;
    logic                  clear_errors;
    logic [DATA_WIDTH-1:0] return_address;
    logic                  empty;
    logic                  full;
    logic [PTR_WIDTH:0]    count;
    logic                  overflow;
    logic                  underflow;

    int checks_cnt = 0;
    int errors_cnt = 0;

    return_address_stack #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .push_enable   (push_enable),
        .push_address  (push_address),
        .pop_enable    (pop_enable),
        .clear_errors  (clear_errors),
        .return_address(return_address),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one clock cycle of strobes, then sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic psh, input logic [DATA_WIDTH-1:0] addr,
                        input logic pp, input logic clr);
        reset        = rst;
        push_enable  = psh;
        push_address = addr;
        pop_enable   = pp;
        clear_errors = clr;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        push_enable  = 1'b0;
        push_address = '0;
        pop_enable   = 1'b0;
        clear_errors = 1'b0;
        $display("step rst=%0b push=%0b addr=%h pop=%0b clr=%0b -> count=%0d top=%h e=%0b f=%0b ovf=%0b unf=%0b",
                 rst, psh, addr, pp, clr, count, return_address, empty, full, overflow, underflow);
    endtask

    task automatic check_state(input string tag, input int exp_count, input logic [15:0] exp_top,
                               input logic exp_ovf, input logic exp_unf);
        check_value({tag, ".count"}, 32'(count), 32'(exp_count));
        check_value({tag, ".top"}, 32'(return_address), 32'(exp_top));
        check_value({tag, ".empty"}, 32'(empty), 32'(exp_count == 0));
        check_value({tag, ".full"}, 32'(full), 32'(exp_count == DEPTH));
        check_value({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
        check_value({tag, ".unf"}, 32'(underflow), 32'(exp_unf));
    endtask

    initial begin
        reset = 1'b1; push_enable = 1'b0; push_address = '0; pop_enable = 1'b0; clear_errors = 1'b0;

        // Reset held two cycles while a push is requested: push ignored.
        step(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
        check_state("reset", 0, 16'h0000, 1'b0, 1'b0);

        // LIFO order.
        step(1'b0, 1'b1, 16'h0011, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0022, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0033, 1'b0, 1'b0);
        check_state("push3", 3, 16'h0033, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check_state("pop1", 2, 16'h0022, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check_state("pop2", 1, 16'h0011, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check_state("pop3", 0, 16'h0000, 1'b0, 1'b0);

        // Fill to DEPTH, then overflow.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
        end
        check_state("fill", 8, 16'h0107, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0999, 1'b0, 1'b0);
        check_state("overflow", 8, 16'h0107, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        check_state("clr_ovf", 8, 16'h0107, 1'b0, 1'b0);
        // Oldest entries intact: pop down to the bottom entry.
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        end
        check_state("drain7", 1, 16'h0100, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check_state("drain8", 0, 16'h0000, 1'b0, 1'b0);

        // Underflow, then clear coinciding with a clean push.
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check_state("underflow", 0, 16'h0000, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h0040, 1'b0, 1'b1);
        check_state("clr_unf", 1, 16'h0040, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Simultaneous push+pop replaces the top.
        step(1'b0, 1'b1, 16'h0011, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0022, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h3333, 1'b1, 1'b0);
        check_state("replace", 2, 16'h3333, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check_state("replace_pop", 1, 16'h0011, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h0055, 1'b1, 1'b0);
        check_state("pushpop_empty", 1, 16'h0055, 1'b0, 1'b1);
        // Set wins over clear when an error coincides with clear_errors.
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        check_state("set_beats_clr", 0, 16'h0000, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Reset mid-operation alongside a pop.
        step(1'b0, 1'b1, 16'h3333, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h4444, 1'b0, 1'b0);
        check_state("pre_reset", 2, 16'h4444, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        check_state("mid_reset", 0, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
        check_state("post_reset", 1, 16'h0001, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
